input_fifo: RTL and testbench
=============================

// Module: input_fifo
// PURPOSE
// - Per-port router input buffer. Sits upstream of the 5-port arbiter: receives
//   flits from a neighbour router over the RTS/CTS handshake and buffers them.
// - Presents the head flit and empty to routing logic; pops on the crossbar grant.
// - One instance per port (N, E, W, S, L).
// PARAMETERS
// - DATA_WIDTH  32  flit width in bits
// - DEPTH       4   FIFO entries; power of two, >= 2
// - PTR_W       $clog2(DEPTH)  pointer width (derived; do not override)
// PORTS
// - clk        in   1           single clock, rising edge
// - rst        in   1           synchronous, active-high reset
// - RX         in   DATA_WIDTH  incoming flit; stable while DRTS=1
// - DRTS       in   1           upstream request-to-send (= upstream RTS)
// - read_en_N  in   1           pop request from the N output (Grant_N)
// - read_en_E  in   1           pop request from the E output (Grant_E)
// - read_en_W  in   1           pop request from the W output (Grant_W)
// - read_en_S  in   1           pop request from the S output (Grant_S)
// - read_en_L  in   1           pop request from the L output (Grant_L)
// - CTS        out  1           clear-to-send to upstream (drives upstream DCTS)
// - empty      out  1           FIFO holds 0 flits
// - full       out  1           FIFO holds DEPTH flits
// - Data_out   out  DATA_WIDTH  head flit, first-word fall-through
// BEHAVIOUR
// - Reset (rst=1 at an edge): rd_ptr=wr_ptr=0, count=0, CTS_FF=0, so CTS=0,
//   empty=1, full=0, Data_out=0. Memory contents are not cleared.
// - Handshake: CTS is registered (CTS_FF).
//   CTS_FF_in = DRTS & !CTS_FF & !full; otherwise CTS_FF_in = 0.
//   A write occurs on the edge where CTS_FF_in=1: mem[wr_ptr]<=RX, wr_ptr++.
//   CTS therefore pulses high for exactly 1 cycle per accepted flit. Upstream
//   drops RTS on seeing RTS&DCTS. Back-to-back flits: at most 1 per 2 cycles.
// - Read: rd_req = OR of the five read_en_*. A pop occurs when rd_req & !empty:
//   rd_ptr++. Data_out = mem[rd_ptr] when !empty, else 0 (combinational).
// - count: +1 on write only, -1 on pop only, unchanged on both/neither.
//   empty = (count==0), full = (count==DEPTH). Both are decoded from registers.
// - Pointers wrap from DEPTH-1 to 0 (modulo DEPTH).
// - Full: CTS is withheld; DRTS stays pending. A pop in the same cycle does not
//   unblock the write; the write is accepted in the next cycle.
// - Empty: rd_req is ignored, with no pointer or count change.
//   A write into an empty FIFO is visible one cycle later (empty=0, Data_out=flit).
// - Simultaneous pop and write with 0 < count < DEPTH: both occur; count unchanged.
// - Multi-hot read_en_*: treated as a single pop (the arbiter guarantees one-hot).
// - rst mid-transfer: a pending CTS is dropped and buffered flits are discarded.
//   Upstream must be reset in the same cycle.
// CONFIGURATION
// - Macro FIFO_CHECKERS_EN.
// - Defined: adds output err [1:0], sticky until rst, reset value 2'b00.
//   err[0] is set when rd_req=1 while empty.
//   err[1] is set when more than one read_en_* is high in a cycle.
//   Other behaviour is identical to the undefined case.
// - Undefined: the err port and its logic are absent.
// TESTING (DATA_WIDTH=32, DEPTH=4)
// - Reset, then DRTS=1, RX=32'hA5A5_0001 -> CTS=1 exactly 1 cycle later for 1 cycle;
//   next cycle empty=0, Data_out=32'hA5A5_0001.
// - Push 4 flits 1..4, no reads -> full=1; a 5th DRTS gets no CTS;
//   read_en_E=1 for 1 cycle -> CTS pulses on the following cycle and flit 5 is stored.
// - Fill 3, pop 1 and push 1 in the same cycle, 6 times -> count stays 3;
//   pointers wrap; pop order equals push order.
// - read_en_L=1 while empty -> no change, Data_out=0;
//   with FIFO_CHECKERS_EN, err=2'b01 and it holds until rst.
// - rst=1 while count=2 and CTS=1 -> next cycle CTS=0, empty=1, Data_out=0.
// - read_en_N=read_en_S=1 with count=2 -> count=1;
//   with FIFO_CHECKERS_EN, err[1]=1.

Source files
------------

// File: rtl/input_fifo.sv
// Router input port buffer: RTS/CTS write side, first-word fall-through read side.
// Optional FIFO_CHECKERS_EN adds a sticky err[1:0] protocol-violation output.
module input_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] Data_out
`ifdef FIFO_CHECKERS_EN
  ,
  output logic [1:0]            err
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  cts_ff;
  logic                  cts_ff_in;
  logic [4:0]            rd_vec;
  logic                  rd_req;
  logic                  do_pop;

  assign rd_vec = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
  assign rd_req = |rd_vec;

  // A write happens on exactly the edge that raises CTS.
  assign cts_ff_in = DRTS & ~cts_ff & ~full;
  assign do_pop    = rd_req & ~empty;

  assign CTS      = cts_ff;
  assign empty    = (count == CNT_W'(0));
  assign full     = (count == CNT_W'(DEPTH));
  assign Data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_ff <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      cts_ff <= cts_ff_in;
      if (cts_ff_in) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      if (cts_ff_in && !do_pop)      count <= count + CNT_W'(1);
      else if (!cts_ff_in && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately left unreset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && cts_ff_in) mem[wr_ptr] <= RX;
  end

`ifdef FIFO_CHECKERS_EN
  logic multi_hot;
  assign multi_hot = (rd_vec & (rd_vec - 5'd1)) != 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 2'b00;
    end else begin
      if (rd_req && empty) err[0] <= 1'b1;
      if (multi_hot)       err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_input_fifo.sv
// Directed bench for input_fifo (DATA_WIDTH=32, DEPTH=4) with an RTS/CTS upstream model.
module tb_input_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] RX = '0;
  logic        DRTS = 1'b0;
  logic        read_en_N = 1'b0, read_en_E = 1'b0, read_en_W = 1'b0;
  logic        read_en_S = 1'b0, read_en_L = 1'b0;
  logic        CTS, empty, full;
  logic [31:0] Data_out;
`ifdef FIFO_CHECKERS_EN
  logic [1:0]  err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .CTS(CTS), .empty(empty), .full(full), .Data_out(Data_out)
`ifdef FIFO_CHECKERS_EN
    , .err(err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Upstream model: hold RTS until CTS is seen, then drop it.
  task automatic push(input logic [31:0] d);
    logic got;
    got = 1'b0;
    DRTS = 1'b1;
    RX = d;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (CTS === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    DRTS = 1'b0;
    check("push_cts", {31'd0, got}, 32'd1);
  endtask

  task automatic pop_n(input logic [31:0] exp);
    check("pop_head", Data_out, exp);
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_cts", {31'd0, CTS}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_data", Data_out, 32'd0);
`ifdef FIFO_CHECKERS_EN
    check("rst_err", {30'd0, err}, 32'd0);
`endif

    // First flit: CTS one cycle after DRTS, for exactly one cycle
    DRTS = 1'b1;
    RX = 32'hA5A5_0001;
    check("pre_cts", {31'd0, CTS}, 32'd0);
    tick();
    check("first_cts_hi", {31'd0, CTS}, 32'd1);
    DRTS = 1'b0;
    tick();
    check("first_cts_lo", {31'd0, CTS}, 32'd0);
    check("first_empty", {31'd0, empty}, 32'd0);
    check("first_data", Data_out, 32'hA5A5_0001);
    pop_n(32'hA5A5_0001);
    check("first_drained", {31'd0, empty}, 32'd1);

    // Fill to full, fifth flit waits until a pop frees a slot
    push(32'd1);
    push(32'd2);
    push(32'd3);
    push(32'd4);
    check("fill_full", {31'd0, full}, 32'd1);
    DRTS = 1'b1;
    RX = 32'd5;
    tick();
    check("full_cts_a", {31'd0, CTS}, 32'd0);
    tick();
    check("full_cts_b", {31'd0, CTS}, 32'd0);
    check("full_still", {31'd0, full}, 32'd1);
    read_en_E = 1'b1;
    tick();
    read_en_E = 1'b0;
    check("pop_cts_still0", {31'd0, CTS}, 32'd0);
    check("pop_notfull", {31'd0, full}, 32'd0);
    check("pop_head2", Data_out, 32'd2);
    tick();
    check("late_cts", {31'd0, CTS}, 32'd1);
    check("late_full", {31'd0, full}, 32'd1);
    DRTS = 1'b0;
    pop_n(32'd2);
    pop_n(32'd3);
    pop_n(32'd4);
    pop_n(32'd5);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Empty read is ignored
    read_en_L = 1'b1;
    tick();
    read_en_L = 1'b0;
    check("er_empty", {31'd0, empty}, 32'd1);
    check("er_full", {31'd0, full}, 32'd0);
    check("er_data", Data_out, 32'd0);
`ifdef FIFO_CHECKERS_EN
    check("er_err", {30'd0, err}, 32'd1);
    tick();
    check("er_err_sticky", {30'd0, err}, 32'd1);
`endif

    // Fill 3, then simultaneous pop+push six times (pointers wrap)
    push(32'h10);
    push(32'h11);
    push(32'h12);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("sim_head", Data_out, 32'h10 + 32'(k));
      DRTS = 1'b1;
      RX = 32'h13 + 32'(k);
      read_en_W = 1'b1;
      tick();
      check("sim_cts", {31'd0, CTS}, 32'd1);
      check("sim_full", {31'd0, full}, 32'd0);
      check("sim_empty", {31'd0, empty}, 32'd0);
      DRTS = 1'b0;
      read_en_W = 1'b0;
      tick();
    end
    pop_n(32'h16);
    pop_n(32'h17);
    pop_n(32'h18);
    check("sim_drained", {31'd0, empty}, 32'd1);

    // Multi-hot read pops once
    push(32'h20);
    push(32'h21);
    read_en_N = 1'b1;
    read_en_S = 1'b1;
    tick();
    read_en_N = 1'b0;
    read_en_S = 1'b0;
    check("mh_empty", {31'd0, empty}, 32'd0);
    check("mh_head", Data_out, 32'h21);
`ifdef FIFO_CHECKERS_EN
    check("mh_err", {30'd0, err}, 32'd3);
`endif
    pop_n(32'h21);
    check("mh_drained", {31'd0, empty}, 32'd1);

    // Reset while count=2 and CTS=1
    push(32'h30);
    tick();
    DRTS = 1'b1;
    RX = 32'h31;
    tick();
    check("mr_cts_hi", {31'd0, CTS}, 32'd1);
    DRTS = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_cts", {31'd0, CTS}, 32'd0);
    check("mr_empty", {31'd0, empty}, 32'd1);
    check("mr_data", Data_out, 32'd0);
`ifdef FIFO_CHECKERS_EN
    check("mr_err", {30'd0, err}, 32'd0);
`endif
    tick();
    check("mr_empty_hold", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
